fifo_multi: RTL

- Parametrised multi-lane FIFO feeding the matrix datapath. Accepts up to N_IN words per cycle and emits bundles of exactly N_OUT words.
- Adds ready/valid handshakes on both sides, occupancy reporting, overflow detection, synchronous flush and compaction of sparse input lanes.
- Sits between the element producers and the matrix multiply/accumulate stages.

---
 rtl/fifo_pkg.sv | 20 ++
 rtl/fifo_multi_lane_compact.sv | 26 ++
 rtl/fifo_multi.sv | 83 ++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared sizing helpers for the multi-lane FIFO family
package fifo_pkg;
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction
   function automatic int popcount(input logic [63:0] v);
      int c;
      c = 0;
      for (int i = 0; i < 64; i++) c += int'(v[i]);
      return c;
   endfunction
   function automatic int depth_of(input int buff_width);
      return 1 << buff_width;
   endfunction
   localparam int DEF_BUFF_WIDTH = 4;
   localparam int DEF_DEPTH = depth_of(DEF_BUFF_WIDTH);
endpackage

// File: rtl/fifo_multi_lane_compact.sv
// lane_compact: packs valid lanes towards lane 0 in ascending order and counts them
module lane_compact
   import fifo_pkg::*;
#(
   parameter int N  = 2,
   parameter int W  = 31,
   localparam int CW = clog2(N + 1)
) (
   input  logic [N-1:0]   valid,
   input  logic [N*W-1:0] data,
   output logic [N*W-1:0] packed_data,
   output logic [CW-1:0]  count
);
   assign count = CW'(popcount(64'(valid)));
   always_comb begin
      int idx;
      idx = 0;
      packed_data = '0;
      for (int k = 0; k < N; k++) begin
         if (valid[k]) begin
            packed_data[idx*W +: W] = data[k*W +: W];
            idx++;
         end
      end
   end
endmodule

// File: rtl/fifo_multi.sv
// fifo_multi: multi-lane input FIFO emitting fixed N_OUT-word bundles with ready/valid on both sides
module fifo_multi
   import fifo_pkg::*;
#(
   parameter int D_WIDTH    = 31,
   parameter int BUFF_WIDTH = 4,
   parameter int N_IN       = 2,
   parameter int N_OUT      = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush,
   input  logic [N_IN-1:0]          in_valid,
   input  logic [N_IN*D_WIDTH-1:0]  in_data,
   output logic                     in_ready,
   output logic [N_OUT*D_WIDTH-1:0] out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [BUFF_WIDTH:0]      level,
   output logic                     overflow
);
   localparam int DEPTH = depth_of(BUFF_WIDTH);
   localparam int LW    = BUFF_WIDTH + 1;
   localparam int CW    = clog2(N_IN + 1);

   if (N_IN > DEPTH || N_OUT > DEPTH) begin : g_bad_params
      $error("fifo_multi: N_IN and N_OUT must not exceed DEPTH");
   end

   logic [D_WIDTH-1:0]      mem [DEPTH];
   logic [BUFF_WIDTH-1:0]   head, tail;
   logic [N_IN*D_WIDTH-1:0] packed_data;
   logic [CW-1:0]           count;
   logic                    push, drop, load;

   lane_compact #(.N(N_IN), .W(D_WIDTH)) u_compact (
      .valid       (in_valid),
      .data        (in_data),
      .packed_data (packed_data),
      .count       (count)
   );

   // Readiness uses registered level only, so a same-cycle pop never admits extra words.
   assign in_ready = level <= LW'(DEPTH - N_IN);
   assign push     = in_ready && |in_valid;
   assign drop     = !in_ready && |in_valid;
   assign load     = (!out_valid || out_ready) && level >= LW'(N_OUT);

   always_ff @(posedge clk) begin
      if (push && !flush)
         for (int j = 0; j < N_IN; j++)
            if (CW'(j) < count) mem[head + BUFF_WIDTH'(j)] <= packed_data[j*D_WIDTH +: D_WIDTH];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head      <= '0;
         tail      <= '0;
         level     <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         overflow  <= 1'b0;
      end else if (flush) begin
         head      <= '0;
         tail      <= '0;
         level     <= '0;
         out_valid <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         if (push) head <= head + BUFF_WIDTH'(count);
         if (drop) overflow <= 1'b1;
         if (load) begin
            for (int j = 0; j < N_OUT; j++)
               out_data[j*D_WIDTH +: D_WIDTH] <= mem[tail + BUFF_WIDTH'(j)];
            tail      <= tail + BUFF_WIDTH'(N_OUT);
            out_valid <= 1'b1;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
         level <= level + (push ? LW'(count) : LW'(0)) - (load ? LW'(N_OUT) : LW'(0));
      end
   end
endmodule
